// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared constants and types for the writeback arbiter
package cpu_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  typedef enum logic [0:0] {
    NORMAL  = 1'b0,
    FORCE_B = 1'b1
  } arb_state_e;

  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

endpackage

// File: rtl/regfile_wb_arbiter_sat_counter.sv
// rtl/regfile_wb_arbiter_sat_counter.sv - saturating up-counter with clear
module sat_counter #(
  parameter int               WIDTH = 4,
  parameter logic [WIDTH-1:0] LIMIT = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] count_next
);

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_next;

  // Clear has priority over increment; the count sticks at LIMIT.
  always_comb begin
    w_next = r_count;
    if (clear) begin
      w_next = '0;
    end else if (inc && (r_count != LIMIT)) begin
      w_next = r_count + WIDTH'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
    end else begin
      r_count <= w_next;
    end
  end

  assign count      = r_count;
  assign count_next = w_next;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - two-source arbiter for the register file write port
module regfile_wb_arbiter
  import cpu_pkg::*;
#(
  parameter int DATA_W       = cpu_pkg::DATA_W,
  parameter int ADDR_W       = cpu_pkg::ADDR_W,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              force_b,
  output logic [CNT_W-1:0]  a_stall_cnt
);

  localparam logic [3:0] LIMIT4 = 4'(STARVE_LIMIT);

  arb_state_e        r_state;
  arb_state_e        w_state_next;
  logic              w_a_ready;
  logic              w_b_ready;
  logic              w_a_acc;
  logic              w_b_acc;
  logic [3:0]        w_wait_unused_cnt;
  logic [3:0]        w_wait_next;
  logic [CNT_W-1:0]  w_stall_unused_next;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;

  // Grant: A wins in NORMAL, B owns the port in FORCE_B; nothing granted in reset.
  always_comb begin
    w_a_ready = 1'b0;
    w_b_ready = 1'b0;
    if (rst_n) begin
      if (r_state == FORCE_B) begin
        w_b_ready = b_valid;
      end else begin
        w_a_ready = a_valid;
        w_b_ready = b_valid && !a_valid;
      end
    end
  end

  assign w_a_acc = a_valid && w_a_ready;
  assign w_b_acc = b_valid && w_b_ready;

  // Consecutive cycles B has been kept waiting.
  sat_counter #(
    .WIDTH (4),
    .LIMIT (LIMIT4)
  ) u_wait_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (!b_valid || w_b_acc),
    .inc        (b_valid && !w_b_ready),
    .count      (w_wait_unused_cnt),
    .count_next (w_wait_next)
  );

  // Cycles A was held off; saturates at all-ones.
  sat_counter #(
    .WIDTH (CNT_W)
  ) u_a_stall_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (1'b0),
    .inc        (a_valid && !w_a_ready),
    .count      (a_stall_cnt),
    .count_next (w_stall_unused_next)
  );

  // Enter FORCE_B when B's wait hits the limit; leave once B is served or withdrawn.
  always_comb begin
    w_state_next = r_state;
    if (r_state == NORMAL) begin
      if (w_wait_next == LIMIT4) begin
        w_state_next = FORCE_B;
      end
    end else if (w_b_acc || !b_valid) begin
      w_state_next = NORMAL;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= NORMAL;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Register the winning write; register 0 is accepted but never written.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else if (w_a_acc) begin
      r_wr_en   <= (a_addr != REG_ZERO);
      r_wr_addr <= a_addr;
      r_wr_data <= a_data;
    end else if (w_b_acc) begin
      r_wr_en   <= (b_addr != REG_ZERO);
      r_wr_addr <= b_addr;
      r_wr_data <= b_data;
    end else begin
      r_wr_en   <= 1'b0;
    end
  end

  assign a_ready = w_a_ready;
  assign b_ready = w_b_ready;
  assign wr_en   = r_wr_en;
  assign wr_addr = r_wr_addr;
  assign wr_data = r_wr_data;
  assign force_b = (r_state == FORCE_B);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_valid, b_valid;
  logic [4:0]  a_addr, b_addr;
  logic [31:0] a_data, b_data;

  logic        a_ready0, b_ready0, wr_en0, force_b0;
  logic [4:0]  wr_addr0;
  logic [31:0] wr_data0;
  logic [15:0] stall0;

  logic        a_ready1, b_ready1, wr_en1, force_b1;
  logic [4:0]  wr_addr1;
  logic [31:0] wr_data1;
  logic [1:0]  stall1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter u0 (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready0),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready0),
    .wr_en(wr_en0), .wr_addr(wr_addr0), .wr_data(wr_data0),
    .force_b(force_b0), .a_stall_cnt(stall0)
  );

  regfile_wb_arbiter #(.STARVE_LIMIT(1), .CNT_W(2)) u1 (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready1),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready1),
    .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1),
    .force_b(force_b1), .a_stall_cnt(stall1)
  );

  // Reference model: B's waiting time in cycles, whether B owns the port next,
  // how many cycles A has been held off, and the last write sent to the register file.
  int          lim  [2] = '{4, 1};
  int          smax [2] = '{65535, 3};
  int          m_wait  [2] = '{0, 0};
  bit          m_force [2] = '{0, 0};
  int          m_stall [2] = '{0, 0};
  bit          m_wr_en [2] = '{0, 0};
  logic [4:0]  m_wr_addr [2];
  logic [31:0] m_wr_data [2];
  bit          m_init = 0;
  bit          la = 0, lb = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check combinational outputs at the falling edge, advance the
  // model across the rising edge, then check registered outputs.
  task automatic cycle();
    bit ga [2];
    bit gb [2];
    logic [63:0] ar, br, fb, st, we, wa, wd;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      ga[i] = 0; gb[i] = 0;
      if (rst_n) begin
        if (m_force[i]) gb[i] = b_valid;
        else if (a_valid) ga[i] = 1;
        else gb[i] = b_valid;
      end
      ar = (i == 0) ? 64'(a_ready0) : 64'(a_ready1);
      br = (i == 0) ? 64'(b_ready0) : 64'(b_ready1);
      chk($sformatf("a_ready[%0d]", i), ar, 64'(ga[i]));
      chk($sformatf("b_ready[%0d]", i), br, 64'(gb[i]));
      if (m_init) begin
        fb = (i == 0) ? 64'(force_b0) : 64'(force_b1);
        st = (i == 0) ? 64'(stall0) : 64'(stall1);
        chk($sformatf("force_b[%0d]", i), fb, 64'(m_force[i]));
        chk($sformatf("stall[%0d]", i), st, 64'(m_stall[i]));
      end
    end
    la = ga[0];
    lb = gb[0];
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_wait[i] = 0; m_force[i] = 0; m_stall[i] = 0;
        m_wr_en[i] = 0; m_wr_addr[i] = '0; m_wr_data[i] = '0;
      end else begin
        if (a_valid && !ga[i] && m_stall[i] < smax[i]) m_stall[i]++;
        if (!b_valid || gb[i]) m_wait[i] = 0;
        else if (m_wait[i] < lim[i]) m_wait[i]++;
        m_force[i] = (m_wait[i] == lim[i]);
        m_wr_en[i] = 0;
        if (ga[i]) begin
          m_wr_en[i] = (a_addr != 0); m_wr_addr[i] = a_addr; m_wr_data[i] = a_data;
        end else if (gb[i]) begin
          m_wr_en[i] = (b_addr != 0); m_wr_addr[i] = b_addr; m_wr_data[i] = b_data;
        end
      end
    end
    if (!rst_n) m_init = 1;
    if (m_init) begin
      for (int i = 0; i < 2; i++) begin
        we = (i == 0) ? 64'(wr_en0) : 64'(wr_en1);
        wa = (i == 0) ? 64'(wr_addr0) : 64'(wr_addr1);
        wd = (i == 0) ? 64'(wr_data0) : 64'(wr_data1);
        chk($sformatf("wr_en[%0d]", i), we, 64'(m_wr_en[i]));
        chk($sformatf("wr_addr[%0d]", i), wa, 64'(m_wr_addr[i]));
        chk($sformatf("wr_data[%0d]", i), wd, 64'(m_wr_data[i]));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with both sources requesting.
    rst_n = 0;
    a_valid = 1; a_addr = 5'd1; a_data = 32'd11;
    b_valid = 1; b_addr = 5'd3; b_data = 32'd33;
    cycle();
    cycle();
    chk("rst_wr_en", 64'(wr_en0), 64'd0);
    chk("rst_wr_addr", 64'(wr_addr0), 64'd0);
    chk("rst_stall", 64'(stall0), 64'd0);
    rst_n = 1;
    cycle();
    chk("first_is_a", 64'(wr_addr0), 64'd1);

    // A only.
    a_valid = 1; a_addr = 5'd2; a_data = 32'd20; b_valid = 0;
    cycle();
    chk("a_only_en", 64'(wr_en0), 64'd1);
    chk("a_only_addr", 64'(wr_addr0), 64'd2);
    chk("a_only_data", 64'(wr_data0), 64'd20);
    a_valid = 0;
    cycle();
    chk("a_only_idle", 64'(wr_en0), 64'd0);

    // Contention: A continuous, B forced in after four waits.
    a_valid = 1; a_addr = 5'd5; a_data = 32'd40;
    b_valid = 1; b_addr = 5'd9; b_data = 32'd35;
    for (int k = 0; k < 4; k++) cycle();
    chk("cont_force", 64'(force_b0), 64'd1);
    chk("cont_b_ready", 64'(b_ready0), 64'd1);
    chk("cont_a_ready", 64'(a_ready0), 64'd0);
    cycle();
    chk("cont_b_addr", 64'(wr_addr0), 64'd9);
    chk("cont_b_data", 64'(wr_data0), 64'd35);
    b_valid = 0;
    cycle();
    chk("cont_a_resume", 64'(wr_addr0), 64'd5);
    chk("cont_stall", 64'(stall0), 64'd1);

    // Register zero via B.
    a_valid = 0; b_valid = 1; b_addr = 5'd0; b_data = 32'd99;
    #1;
    chk("r0_b_ready", 64'(b_ready0), 64'd1);
    cycle();
    chk("r0_no_write", 64'(wr_en0), 64'd0);

    // B abandon after two waits, then a fresh B needs four waits.
    a_valid = 1; b_valid = 1; b_addr = 5'd7; b_data = 32'd70;
    cycle(); cycle();
    b_valid = 0;
    cycle();
    chk("abandon_no_force", 64'(force_b0), 64'd0);
    b_valid = 1;
    cycle(); cycle(); cycle();
    chk("abandon_three", 64'(force_b0), 64'd0);
    cycle();
    chk("abandon_four", 64'(force_b0), 64'd1);
    a_valid = 0;
    cycle();

    // Stall counter saturation on the narrow instance, then reset.
    a_valid = 1; b_valid = 1;
    for (int k = 0; k < 8; k++) cycle();
    chk("sat_stall", 64'(stall1), 64'd3);
    rst_n = 0;
    cycle();
    chk("sat_reset", 64'(stall1), 64'd0);
    rst_n = 1;

    // Randomized traffic respecting the hold-until-accepted rule.
    for (int k = 0; k < 400; k++) begin
      rst_n = ($urandom_range(0, 59) != 0);
      if (!a_valid || la) begin
        a_valid = ($urandom_range(0, 3) != 0);
        a_addr  = 5'($urandom_range(0, 31));
        a_data  = $urandom;
      end
      if (!b_valid || lb) begin
        b_valid = ($urandom_range(0, 2) != 0);
        b_addr  = 5'($urandom_range(0, 31));
        b_data  = $urandom;
      end else if ($urandom_range(0, 15) == 0) begin
        b_valid = 0;
      end
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Shares the register file's single write port (RegWrite / Write_r / Data) between two writeback sources. Source A is the in-order pipeline WB stage and has priority. Source B is the long-latency unit (load/multi-cycle result).
- Accepted writes are registered and driven to the register file one cycle later.
- A starvation guard forces a B grant after a bounded wait.
- A saturating stall counter exposes how often A is stalled by the guard.

Parameters:
DATA_W, 32, register data width
ADDR_W, 5, register index width (32 registers)
STARVE_LIMIT, 4, consecutive B-wait cycles before B is force-granted (1..15)
CNT_W, 16, width of the A-stall statistics counter

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  synchronous reset, active-low
a_valid  in  1  source A write request
a_addr  in  ADDR_W  source A destination register
a_data  in  DATA_W  source A write data
a_ready  out  1  source A accepted this cycle (combinational)
b_valid  in  1  source B write request
b_addr  in  ADDR_W  source B destination register
b_data  in  DATA_W  source B write data
b_ready  out  1  source B accepted this cycle (combinational)
wr_en  out  1  to register file RegWrite
wr_addr  out  ADDR_W  to register file Write_r
wr_data  out  DATA_W  to register file Data
force_b  out  1  high while state is FORCE_B
a_stall_cnt  out  CNT_W  saturating count of cycles with a_valid && !a_ready

Behaviour:
- Reset, sampled on a clk edge while rst_n=0: wr_en=0, wr_addr=0, wr_data=0, wait_cnt=0, state=NORMAL, a_stall_cnt=0.
- While rst_n=0, a_ready=0 and b_ready=0. A request held across reset release is accepted no earlier than the first cycle with rst_n=1.
- Handshake: a transfer occurs when valid && ready.
  - A source holds valid/addr/data stable until accepted.
  - valid must not depend on ready.
  - At most one transfer per cycle.
- FSM states: NORMAL, FORCE_B.
- NORMAL arbitration:
  - a_ready = a_valid.
  - b_ready = b_valid && !a_valid.
- FORCE_B arbitration:
  - b_ready = b_valid.
  - a_ready = 0.
- wait_cnt (4 bits):
  - Clears when b_valid=0 or B is accepted.
  - Otherwise increments while b_valid && !b_ready, saturating at STARVE_LIMIT.
- Transitions:
  - NORMAL -> FORCE_B when the next wait_cnt equals STARVE_LIMIT.
  - FORCE_B -> NORMAL on B acceptance, or if b_valid drops (abandon is legal only for a flushed B).
- Output register, updated on the cycle after acceptance (latency 1):
  - wr_en = 1 if a transfer occurred and addr != 0.
  - wr_addr and wr_data take the winner's values.
  - With no transfer, wr_en=0 and wr_addr/wr_data hold their previous values.
- Register 0: writes to address 0 are accepted (ready=1) but never produce wr_en=1.
- Same address on A and B in the same cycle: the grant rules above apply. WAW ordering between sources is the issue logic's responsibility, not this block's.
- a_stall_cnt: +1 each cycle with a_valid && !a_ready; saturates at all-ones; cleared only by reset.
- force_b = (state == FORCE_B), unregistered decode of the state flop.
- Reset mid-operation: pending requests are not remembered. The sources must re-present them after reset.

Decomposition:
- Shared package cpu_pkg:
  - ADDR_W/DATA_W constants.
  - Arbiter state enum {NORMAL, FORCE_B}.
  - Constant REG_ZERO = 0.
- One natural sub-module: sat_counter (parameterised width and limit, with clear and increment inputs). It is instantiated twice: wait_cnt and a_stall_cnt.
- Top-level glue:
  - grant logic;
  - FSM;
  - output register.

Test Plan:
1. Reset: hold rst_n=0 for 2 cycles with a_valid=b_valid=1 -> a_ready=b_ready=0, wr_en=0, wr_addr=0, wr_data=0, a_stall_cnt=0; release -> first acceptance is A.
2. A only: a_valid=1, a_addr=2, a_data=20 for 1 cycle -> a_ready=1 that cycle; next cycle wr_en=1, wr_addr=2, wr_data=20; the cycle after, wr_en=0.
3. Contention with STARVE_LIMIT=4: a_valid=1 continuously (addr 5, data 40), b_valid=1 (addr 9, data 35) ->
   - A accepted for 4 cycles;
   - force_b=1 in cycle 5 with b_ready=1, a_ready=0;
   - wr_addr=9, wr_data=35 the following cycle;
   - A resumes;
   - a_stall_cnt=1.
4. Register zero: b_valid=1, b_addr=0, b_data=99, a_valid=0 -> b_ready=1, wr_en stays 0 the next cycle.
5. B abandon: B waits 2 cycles behind A, then b_valid=0 -> wait_cnt clears, no force_b. A later B request needs a full 4 waits before forcing.
6. Stall counter saturation, with CNT_W=2 and STARVE_LIMIT=1 and both sources continuously valid -> a_stall_cnt reaches 3 and stays 3. Reset mid-sequence returns it to 0.
